dff_edge_monitor: RTL and testbench

//  Downstream consumer of the D flip-flop stage output (out). Registers the Q stream, removes

---
 rtl/dff_edge_monitor.sv | 207 ++++++++++++++++++++
 tb/tb_dff_edge_monitor.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dff_edge_monitor.sv
`default_nettype none
// ============================================================================
// Module      : dff_edge_monitor
// Description : Sits downstream of a D flip-flop stage in the same clock
//               domain. It registers the Q stream and rejects pulses shorter
//               than STABLE clocks. It publishes a filtered level with
//               one-cycle rise/fall pulses, and counts qualified rising edges.
//
// Parameters  : STABLE   - consecutive registered samples that must differ
//                          from the level before it flips (>= 1)
//               CNT_W    - width of the rising-edge counter
//               SATURATE - 0: counter wraps to 0 past max
//                          1: counter holds at max
//
// Ports       : clk      in   1      rising-edge clock, shared with the FF stage
//               rst_n    in   1      asynchronous, active-low reset
//               i_q      in   1      Q output of the flip-flop stage
//               i_en     in   1      counting enable (the filter always runs)
//               i_clr    in   1      synchronous clear of count and overflow
//               o_level  out  1      filtered level
//               o_rise   out  1      one-cycle pulse on a qualified 0->1 change
//               o_fall   out  1      one-cycle pulse on a qualified 1->0 change
//               o_count  out  CNT_W  qualified rising edges counted while enabled
//               o_ovf    out  1      sticky, set when the count would pass max
//
// Revision    : 1.0 - initial release
// ============================================================================
module dff_edge_monitor #(
    parameter int STABLE   = 2,
    parameter int CNT_W    = 8,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_q,
    input  logic             i_en,
    input  logic             i_clr,
    output logic             o_level,
    output logic             o_rise,
    output logic             o_fall,
    output logic [CNT_W-1:0] o_count,
    output logic             o_ovf
);

    // The run counter only has to reach STABLE-1. Keep at least one bit so
    // the STABLE=1 build still elaborates.
    localparam int                RUN_W      = (STABLE < 2) ? 1 : $clog2(STABLE);
    localparam logic [RUN_W-1:0]  C_RUN_LAST = RUN_W'(STABLE - 1);
    localparam logic [RUN_W-1:0]  C_RUN_ONE  = RUN_W'(1);
    localparam logic [CNT_W-1:0]  C_CNT_MAX  = '1;

    typedef enum logic [1:0] {
        S_LOW   = 2'd0,
        S_CHK_H = 2'd1,
        S_HIGH  = 2'd2,
        S_CHK_L = 2'd3
    } state_t;

    logic             r_q;
    state_t           r_state;
    state_t           w_state_nxt;
    logic [RUN_W-1:0] r_run;
    logic [RUN_W-1:0] w_run_nxt;
    logic             r_level;
    logic             w_level_nxt;
    logic             r_rise;
    logic             w_rise_nxt;
    logic             r_fall;
    logic             w_fall_nxt;
    logic [CNT_W-1:0] r_count;
    logic             r_ovf;
    logic             w_cnt_at_max;

    // ------------------------------------------------------------------
    // Input stage: one register on the incoming Q stream.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= 1'b0;
        end else begin
            r_q <= i_q;
        end
    end

    // ------------------------------------------------------------------
    // Filter FSM: state, run counter and registered level/pulse outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_LOW;
            r_run   <= '0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_run   <= w_run_nxt;
            r_level <= w_level_nxt;
            r_rise  <= w_rise_nxt;
            r_fall  <= w_fall_nxt;
        end
    end

    // The first differing sample counts as run=1. The state flips once the
    // STABLE-th consecutive differing sample is seen. Any sample that agrees
    // with the current level drops back to the settled state and discards the
    // run. Pulses default low, so each one lasts exactly one cycle. Rise and
    // fall can never be set together.
    always_comb begin
        w_state_nxt = r_state;
        w_run_nxt   = r_run;
        w_level_nxt = r_level;
        w_rise_nxt  = 1'b0;
        w_fall_nxt  = 1'b0;
        case (r_state)
            S_LOW: begin
                if (r_q) begin
                    if (STABLE == 1) begin
                        w_state_nxt = S_HIGH;
                        w_level_nxt = 1'b1;
                        w_rise_nxt  = 1'b1;
                        w_run_nxt   = '0;
                    end else begin
                        w_state_nxt = S_CHK_H;
                        w_run_nxt   = C_RUN_ONE;
                    end
                end
            end
            S_CHK_H: begin
                if (!r_q) begin
                    w_state_nxt = S_LOW;
                    w_run_nxt   = '0;
                end else if (r_run == C_RUN_LAST) begin
                    w_state_nxt = S_HIGH;
                    w_level_nxt = 1'b1;
                    w_rise_nxt  = 1'b1;
                    w_run_nxt   = '0;
                end else begin
                    w_run_nxt   = r_run + C_RUN_ONE;
                end
            end
            S_HIGH: begin
                if (!r_q) begin
                    if (STABLE == 1) begin
                        w_state_nxt = S_LOW;
                        w_level_nxt = 1'b0;
                        w_fall_nxt  = 1'b1;
                        w_run_nxt   = '0;
                    end else begin
                        w_state_nxt = S_CHK_L;
                        w_run_nxt   = C_RUN_ONE;
                    end
                end
            end
            S_CHK_L: begin
                if (r_q) begin
                    w_state_nxt = S_HIGH;
                    w_run_nxt   = '0;
                end else if (r_run == C_RUN_LAST) begin
                    w_state_nxt = S_LOW;
                    w_level_nxt = 1'b0;
                    w_fall_nxt  = 1'b1;
                    w_run_nxt   = '0;
                end else begin
                    w_run_nxt   = r_run + C_RUN_ONE;
                end
            end
            default: begin
                w_state_nxt = S_LOW;
                w_run_nxt   = '0;
                w_level_nxt = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Rising-edge counter. It works from the registered rise pulse, so the
    // count moves one edge after the rise is visible. Clear wins over
    // increment.
    // ------------------------------------------------------------------
    assign w_cnt_at_max = (r_count == C_CNT_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else if (i_clr) begin
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else if (i_en && r_rise) begin
            if (w_cnt_at_max) begin
                r_ovf   <= 1'b1;
                r_count <= (SATURATE != 0) ? C_CNT_MAX : '0;
            end else begin
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

    assign o_level = r_level;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;
    assign o_count = r_count;
    assign o_ovf   = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_dff_edge_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_dff_edge_monitor
// Description : Self-checking bench for dff_edge_monitor. It runs a wrapping
//               instance and a saturating instance side by side on the same
//               stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dff_edge_monitor;

    localparam int STABLE = 2;
    localparam int CNT_W  = 8;
    localparam int MAXV   = (1 << CNT_W) - 1;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic             i_q   = 1'b0;
    logic             i_en  = 1'b0;
    logic             i_clr = 1'b0;

    logic             o_level, o_rise, o_fall, o_ovf;
    logic [CNT_W-1:0] o_count;
    logic             s_level, s_rise, s_fall, s_ovf;
    logic [CNT_W-1:0] s_count;

    dff_edge_monitor #(.STABLE(STABLE), .CNT_W(CNT_W), .SATURATE(0)) dut (
        .clk(clk), .rst_n(rst_n), .i_q(i_q), .i_en(i_en), .i_clr(i_clr),
        .o_level(o_level), .o_rise(o_rise), .o_fall(o_fall),
        .o_count(o_count), .o_ovf(o_ovf)
    );

    dff_edge_monitor #(.STABLE(STABLE), .CNT_W(CNT_W), .SATURATE(1)) dut_s (
        .clk(clk), .rst_n(rst_n), .i_q(i_q), .i_en(i_en), .i_clr(i_clr),
        .o_level(s_level), .o_rise(s_rise), .o_fall(s_fall),
        .o_count(s_count), .o_ovf(s_ovf)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model. The level flips when the last STABLE input samples
    // before an edge all differ from it. The counter advances on the edge
    // after a rise.
    // ------------------------------------------------------------------
    logic m_hist [STABLE];
    logic m_level, m_rise, m_fall, m_ovf, m_ovf_s;
    int   m_cnt, m_cnt_s;

    task automatic model_reset();
        for (int i = 0; i < STABLE; i++) m_hist[i] = 1'b0;
        m_level = 1'b0; m_rise = 1'b0; m_fall = 1'b0;
        m_cnt = 0; m_cnt_s = 0; m_ovf = 1'b0; m_ovf_s = 1'b0;
    endtask

    task automatic model_step();
        logic all_diff;
        if (i_clr) begin
            m_cnt = 0; m_cnt_s = 0; m_ovf = 1'b0; m_ovf_s = 1'b0;
        end else if (i_en && m_rise) begin
            if (m_cnt == MAXV) begin m_cnt = 0; m_ovf = 1'b1; end
            else m_cnt = m_cnt + 1;
            if (m_cnt_s == MAXV) m_ovf_s = 1'b1;
            else m_cnt_s = m_cnt_s + 1;
        end
        all_diff = 1'b1;
        for (int i = 0; i < STABLE; i++) if (m_hist[i] == m_level) all_diff = 1'b0;
        m_rise = all_diff && !m_level;
        m_fall = all_diff && m_level;
        if (all_diff) m_level = !m_level;
        for (int i = 0; i < STABLE - 1; i++) m_hist[i] = m_hist[i+1];
        m_hist[STABLE-1] = i_q;
    endtask

    // One clock: the model samples inputs at the edge and outputs are read 1
    // time unit later. Inputs change only after that point.
    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step();
        #1;
    endtask

    task automatic check_model();
        chk("rnd_level", {31'd0, o_level}, {31'd0, m_level});
        chk("rnd_rise",  {31'd0, o_rise},  {31'd0, m_rise});
        chk("rnd_fall",  {31'd0, o_fall},  {31'd0, m_fall});
        chk("rnd_count", {24'd0, o_count}, m_cnt);
        chk("rnd_ovf",   {31'd0, o_ovf},   {31'd0, m_ovf});
        chk("rnd_count_sat", {24'd0, s_count}, m_cnt_s);
        chk("rnd_ovf_sat",   {31'd0, s_ovf},   {31'd0, m_ovf_s});
    endtask

    // Hold the input high then low, tallying rise pulses seen.
    task automatic pulse(input int hi, input int lo, inout int rises);
        i_q = 1'b1;
        repeat (hi) begin tick(); rises += int'(o_rise); end
        i_q = 1'b0;
        repeat (lo) begin tick(); rises += int'(o_rise); end
    endtask

    typedef struct {
        logic q; logic clr;
        logic lvl; logic rise; logic fall; int cnt;
    } vec_t;

    vec_t vecs [19];
    int   rises;

    initial begin
        // Hand-derived STABLE=2 sequence starting from reset with en=1.
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0};
        vecs[2]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 0}; // rise at E0+2
        vecs[3]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1}; // count one edge later
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1};
        vecs[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1}; // one-clock low glitch
        vecs[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1}; // fall
        vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1}; // one-clock high glitch
        vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1};
        vecs[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1}; // two-clock pulse
        vecs[14] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1};
        vecs[15] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1};
        vecs[16] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2};
        vecs[17] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2};
        vecs[18] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0}; // clear

        // ---- T1: reset held with input high ----
        rst_n = 1'b0; model_reset();
        i_q = 1'b1; i_en = 1'b1; i_clr = 1'b0;
        #1;
        chk("rst_async_level", {31'd0, o_level}, 0);
        repeat (3) begin
            tick();
            chk("rst_outputs", {25'd0, o_level, o_rise, o_fall, o_ovf, o_count == 0 ? 1'b0 : 1'b1}, 0);
        end
        rst_n = 1'b1;
        tick(); chk("t1_e1_rise", {31'd0, o_rise}, 0);
        tick(); chk("t1_e2_rise", {31'd0, o_rise}, 0);
        tick(); chk("t1_e3_rise", {31'd0, o_rise}, 1);
        chk("t1_e3_level", {31'd0, o_level}, 1);

        // ---- table: latency, glitches, pulse pair, clear ----
        rst_n = 1'b0; model_reset(); i_q = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int v = 0; v < 19; v++) begin
            i_q = vecs[v].q; i_clr = vecs[v].clr;
            tick();
            chk($sformatf("vec%0d_level", v), {31'd0, o_level}, {31'd0, vecs[v].lvl});
            chk($sformatf("vec%0d_rise", v),  {31'd0, o_rise},  {31'd0, vecs[v].rise});
            chk($sformatf("vec%0d_fall", v),  {31'd0, o_fall},  {31'd0, vecs[v].fall});
            chk($sformatf("vec%0d_count", v), {24'd0, o_count}, vecs[v].cnt);
            chk($sformatf("vec%0d_ovf", v),   {31'd0, o_ovf},   0);
        end
        i_clr = 1'b0;

        // ---- T5: clear on the increment edge, then counting disabled ----
        rises = 0;
        pulse(3, 3, rises);
        chk("t5_count_before", {24'd0, o_count}, 1);
        i_q = 1'b1;
        tick(); tick(); tick();
        chk("t5_rise_seen", {31'd0, o_rise}, 1);
        i_clr = 1'b1; i_q = 1'b0;
        tick();
        chk("t5_clr_wins_count", {24'd0, o_count}, 0);
        chk("t5_clr_wins_ovf",   {31'd0, o_ovf}, 0);
        i_clr = 1'b0;
        tick(); tick();
        pulse(3, 3, rises);
        chk("t5_count_one", {24'd0, o_count}, 1);
        i_en = 1'b0; rises = 0;
        repeat (5) pulse(3, 3, rises);
        chk("t5_en0_rises", rises, 5);
        chk("t5_en0_count", {24'd0, o_count}, 1);
        i_en = 1'b1;

        // ---- T4: wrap vs saturate ----
        i_clr = 1'b1; tick(); i_clr = 1'b0;
        rises = 0;
        repeat (255) pulse(3, 3, rises);
        chk("t4_count_255",     {24'd0, o_count}, 255);
        chk("t4_ovf_255",       {31'd0, o_ovf},   0);
        chk("t4_sat_count_255", {24'd0, s_count}, 255);
        pulse(3, 3, rises);
        chk("t4_rises",         rises, 256);
        chk("t4_wrap_count",    {24'd0, o_count}, 0);
        chk("t4_wrap_ovf",      {31'd0, o_ovf},   1);
        chk("t4_sat_count",     {24'd0, s_count}, 255);
        chk("t4_sat_ovf",       {31'd0, s_ovf},   1);
        pulse(3, 3, rises);
        chk("t4_wrap_after",    {24'd0, o_count}, 1);
        chk("t4_ovf_sticky",    {31'd0, o_ovf},   1);
        chk("t4_sat_hold",      {24'd0, s_count}, 255);

        // ---- T6: asynchronous reset in the middle of a qualification ----
        i_clr = 1'b1; tick(); i_clr = 1'b0;
        rises = 0;
        pulse(3, 3, rises);
        chk("t6_count_pre", {24'd0, o_count}, 1);
        i_q = 1'b1;
        tick(); tick();           // state is now in the high-qualification run
        #2;
        rst_n = 1'b0; model_reset();
        #1;
        chk("t6_async_count", {24'd0, o_count}, 0);
        chk("t6_async_level", {31'd0, o_level}, 0);
        chk("t6_async_rise",  {31'd0, o_rise},  0);
        i_q = 1'b0;
        tick();
        rst_n = 1'b1;
        rises = 0;
        repeat (4) begin tick(); rises += int'(o_rise); end
        chk("t6_no_rise_after", rises, 0);
        chk("t6_level_after",   {31'd0, o_level}, 0);

        // ---- randomized run against the model ----
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 3) == 0) i_q = ~i_q;
            i_en  = ($urandom_range(0, 7) != 0);
            i_clr = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 599) == 0) begin
                rst_n = 1'b0; model_reset();
                tick();
                rst_n = 1'b1;
            end
            tick();
            check_model();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
